// File: rtl/de_pipe.sv
// rtl/de_pipe.sv - decode-to-execute pipeline register with hazard control and event counters
module de_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       d_stat_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       D_ifun_i,
    input  logic [63:0]      d_valC_i,
    input  logic [63:0]      d_valA_i,
    input  logic [63:0]      d_valB_i,
    input  logic [3:0]       d_dstE_i,
    input  logic [3:0]       d_dstM_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       m_stat_i,
    input  logic [3:0]       W_stat_i,
    output logic [3:0]       E_stat_o,
    output logic [3:0]       E_icode_o,
    output logic [3:0]       E_ifun_o,
    output logic [63:0]      E_valC_o,
    output logic [63:0]      E_valA_o,
    output logic [63:0]      E_valB_o,
    output logic [3:0]       E_dstE_o,
    output logic [3:0]       E_dstM_o,
    output logic [3:0]       E_srcA_o,
    output logic [3:0]       E_srcB_o,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             set_cc_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] SAOK    = 4'h1;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic load_use;
    logic ret_haz;
    logic mispred;
    logic exc_mw;

    always_comb begin
        load_use = ((E_icode_o == IMRMOVQ) || (E_icode_o == IPOPQ)) &&
                   (E_dstM_o != RNONE) &&
                   ((E_dstM_o == d_srcA_i) || (E_dstM_o == d_srcB_i));
        ret_haz  = (D_icode_i == IRET) || (E_icode_o == IRET) || (M_icode_i == IRET);
        mispred  = (E_icode_o == IJXX) && !e_Cnd_i;
        exc_mw   = (m_stat_i != SAOK) || (W_stat_i != SAOK);
    end

    assign F_stall_o  = load_use || ret_haz;
    assign D_stall_o  = load_use;
    assign D_bubble_o = mispred || (ret_haz && !load_use);
    assign E_bubble_o = mispred || load_use;
    assign M_bubble_o = exc_mw;
    assign set_cc_o   = (E_icode_o == IOPQ) && !exc_mw;

    // E never stalls: each edge loads either a bubble or the decode-stage values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            E_stat_o  <= SAOK;
            E_icode_o <= INOP;
            E_ifun_o  <= 4'h0;
            E_valC_o  <= 64'h0;
            E_valA_o  <= 64'h0;
            E_valB_o  <= 64'h0;
            E_dstE_o  <= RNONE;
            E_dstM_o  <= RNONE;
            E_srcA_o  <= RNONE;
            E_srcB_o  <= RNONE;
        end else if (E_bubble_o) begin
            E_stat_o  <= SAOK;
            E_icode_o <= INOP;
            E_ifun_o  <= 4'h0;
            E_valC_o  <= 64'h0;
            E_valA_o  <= 64'h0;
            E_valB_o  <= 64'h0;
            E_dstE_o  <= RNONE;
            E_dstM_o  <= RNONE;
            E_srcA_o  <= RNONE;
            E_srcB_o  <= RNONE;
        end else begin
            E_stat_o  <= d_stat_i;
            E_icode_o <= D_icode_i;
            E_ifun_o  <= D_ifun_i;
            E_valC_o  <= d_valC_i;
            E_valA_o  <= d_valA_i;
            E_valB_o  <= d_valB_i;
            E_dstE_o  <= d_dstE_i;
            E_dstM_o  <= d_dstM_i;
            E_srcA_o  <= d_srcA_i;
            E_srcB_o  <= d_srcB_i;
        end
    end

    // Saturating hazard-event counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (D_stall_o && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (E_bubble_o && (bubble_cnt_o != CNT_MAX)) begin
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_de_pipe.sv
// tb/tb_de_pipe.sv - scoreboard bench for de_pipe with directed hazard vectors
module tb_de_pipe;

    localparam int K_FST = 0, K_DST = 1, K_DBUB = 2, K_EBUB = 3, K_MBUB = 4, K_SCC = 5;
    localparam int K_EICODE = 6, K_EVALA = 7, K_EDSTE = 8, K_EDSTM = 9, K_ESTAT = 10;
    localparam int K_SCNT = 11, K_BCNT = 12, K_SCNT4 = 13, K_BCNT4 = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d_stat, d_icode, d_ifun, d_dste, d_dstm, d_srca, d_srcb;
    logic [63:0] d_valc, d_vala, d_valb;
    logic        e_cnd;
    logic [3:0]  m_icode, m_stat, w_stat;

    logic [3:0]  e_stat, e_icode, e_ifun, e_dste, e_dstm, e_srca, e_srcb;
    logic [63:0] e_valc, e_vala, e_valb;
    logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, set_cc;
    logic [31:0] stall_cnt, bubble_cnt;

    logic [3:0]  e4_stat, e4_icode, e4_ifun, e4_dste, e4_dstm, e4_srca, e4_srcb;
    logic [63:0] e4_valc, e4_vala, e4_valb;
    logic        f4_stall, d4_stall, d4_bubble, e4_bubble, m4_bubble, set4_cc;
    logic [3:0]  stall_cnt4, bubble_cnt4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [63:0] act;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    de_pipe dut (
        .clk_i(clk), .rst_n_i(rst_n), .d_stat_i(d_stat), .D_icode_i(d_icode), .D_ifun_i(d_ifun),
        .d_valC_i(d_valc), .d_valA_i(d_vala), .d_valB_i(d_valb),
        .d_dstE_i(d_dste), .d_dstM_i(d_dstm), .d_srcA_i(d_srca), .d_srcB_i(d_srcb),
        .e_Cnd_i(e_cnd), .M_icode_i(m_icode), .m_stat_i(m_stat), .W_stat_i(w_stat),
        .E_stat_o(e_stat), .E_icode_o(e_icode), .E_ifun_o(e_ifun),
        .E_valC_o(e_valc), .E_valA_o(e_vala), .E_valB_o(e_valb),
        .E_dstE_o(e_dste), .E_dstM_o(e_dstm), .E_srcA_o(e_srca), .E_srcB_o(e_srcb),
        .F_stall_o(f_stall), .D_stall_o(d_stall), .D_bubble_o(d_bubble),
        .E_bubble_o(e_bubble), .M_bubble_o(m_bubble), .set_cc_o(set_cc),
        .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
    );

    de_pipe #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .d_stat_i(d_stat), .D_icode_i(d_icode), .D_ifun_i(d_ifun),
        .d_valC_i(d_valc), .d_valA_i(d_vala), .d_valB_i(d_valb),
        .d_dstE_i(d_dste), .d_dstM_i(d_dstm), .d_srcA_i(d_srca), .d_srcB_i(d_srcb),
        .e_Cnd_i(e_cnd), .M_icode_i(m_icode), .m_stat_i(m_stat), .W_stat_i(w_stat),
        .E_stat_o(e4_stat), .E_icode_o(e4_icode), .E_ifun_o(e4_ifun),
        .E_valC_o(e4_valc), .E_valA_o(e4_vala), .E_valB_o(e4_valb),
        .E_dstE_o(e4_dste), .E_dstM_o(e4_dstm), .E_srcA_o(e4_srca), .E_srcB_o(e4_srcb),
        .F_stall_o(f4_stall), .D_stall_o(d4_stall), .D_bubble_o(d4_bubble),
        .E_bubble_o(e4_bubble), .M_bubble_o(m4_bubble), .set_cc_o(set4_cc),
        .stall_cnt_o(stall_cnt4), .bubble_cnt_o(bubble_cnt4)
    );

    function automatic logic [63:0] sample(int k);
        case (k)
            K_FST:    return {63'h0, f_stall};
            K_DST:    return {63'h0, d_stall};
            K_DBUB:   return {63'h0, d_bubble};
            K_EBUB:   return {63'h0, e_bubble};
            K_MBUB:   return {63'h0, m_bubble};
            K_SCC:    return {63'h0, set_cc};
            K_EICODE: return {60'h0, e_icode};
            K_EVALA:  return e_vala;
            K_EDSTE:  return {60'h0, e_dste};
            K_EDSTM:  return {60'h0, e_dstm};
            K_ESTAT:  return {60'h0, e_stat};
            K_SCNT:   return {32'h0, stall_cnt};
            K_BCNT:   return {32'h0, bubble_cnt};
            K_SCNT4:  return {60'h0, stall_cnt4};
            K_BCNT4:  return {60'h0, bubble_cnt4};
            default:  return 64'hDEAD;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the current cycle, away from the edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            act = sample(cur.kind);
            total++;
            if (act === cur.val) passed++;
            else $display("FAIL %s (cycle %0d): got %0h, expected %0h", cur.name, cur.cyc, act, cur.val);
        end
    end

    task automatic chk(input int k, input logic [63:0] v, input string n);
        exp_t e;
        e.cyc = cyc; e.kind = k; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic defaults();
        d_stat = 4'h1; d_icode = 4'h1; d_ifun = 4'h0;
        d_valc = '0; d_vala = '0; d_valb = '0;
        d_dste = 4'hF; d_dstm = 4'hF; d_srca = 4'hF; d_srcb = 4'hF;
        e_cnd = 1'b1; m_icode = 4'h1; m_stat = 4'h1; w_stat = 4'h1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        defaults();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        defaults();
        step();
        chk(K_EICODE, 64'h1, "rst_icode"); chk(K_EDSTE, 64'hF, "rst_dstE");
        chk(K_SCNT, 64'h0, "rst_scnt");    chk(K_BCNT, 64'h0, "rst_bcnt");
        chk(K_ESTAT, 64'h1, "rst_stat");   chk(K_FST, 64'h0, "rst_fstall");

        step(); rst_n = 1'b1;
        d_icode = 4'h6; d_vala = 64'h1234; d_dste = 4'h3;
        chk(K_FST, 64'h0, "pass_fstall"); chk(K_EBUB, 64'h0, "pass_ebub"); chk(K_SCC, 64'h0, "pass_scc_nop");

        step(); d_icode = 4'h5; d_dstm = 4'h2;
        chk(K_EICODE, 64'h6, "pass_icode"); chk(K_EVALA, 64'h1234, "pass_valA");
        chk(K_EDSTE, 64'h3, "pass_dstE");   chk(K_SCC, 64'h1, "pass_scc");

        step(); d_icode = 4'h6; d_srcb = 4'h2;
        chk(K_FST, 64'h1, "lu_fstall"); chk(K_DST, 64'h1, "lu_dstall");
        chk(K_EBUB, 64'h1, "lu_ebub");  chk(K_DBUB, 64'h0, "lu_dbub");

        step(); d_icode = 4'h7; d_ifun = 4'h1;
        chk(K_EICODE, 64'h1, "lu_bubble_icode"); chk(K_EDSTM, 64'hF, "lu_bubble_dstM");
        chk(K_SCNT, 64'h1, "lu_scnt");           chk(K_BCNT, 64'h1, "lu_bcnt");

        step(); d_icode = 4'h6; e_cnd = 1'b0;
        chk(K_DBUB, 64'h1, "mp_dbub"); chk(K_EBUB, 64'h1, "mp_ebub");
        chk(K_FST, 64'h0, "mp_fstall"); chk(K_DST, 64'h0, "mp_dstall");

        step(); d_icode = 4'h9;
        chk(K_EICODE, 64'h1, "mp_bubble_icode"); chk(K_BCNT, 64'h2, "mp_bcnt"); chk(K_SCNT, 64'h1, "mp_scnt");
        chk(K_FST, 64'h1, "ret_d_fstall"); chk(K_DBUB, 64'h1, "ret_d_dbub"); chk(K_EBUB, 64'h0, "ret_d_ebub");

        step();
        chk(K_EICODE, 64'h9, "ret_e_icode");
        chk(K_FST, 64'h1, "ret_e_fstall"); chk(K_DBUB, 64'h1, "ret_e_dbub"); chk(K_EBUB, 64'h0, "ret_e_ebub");

        step(); m_icode = 4'h9; d_icode = 4'h6;
        chk(K_EICODE, 64'h1, "ret_m_icode");
        chk(K_FST, 64'h1, "ret_m_fstall"); chk(K_DBUB, 64'h1, "ret_m_dbub"); chk(K_EBUB, 64'h0, "ret_m_ebub");

        step(); m_stat = 4'h2; d_icode = 4'h5; d_dstm = 4'h4;
        chk(K_EICODE, 64'h6, "exc_icode"); chk(K_MBUB, 64'h1, "exc_mbub");
        chk(K_SCC, 64'h0, "exc_scc");      chk(K_FST, 64'h0, "exc_fstall");

        step(); d_icode = 4'h6; d_srca = 4'h4; d_srcb = 4'h4;
        chk(K_FST, 64'h1, "dual_fstall"); chk(K_DST, 64'h1, "dual_dstall");
        chk(K_EBUB, 64'h1, "dual_ebub");  chk(K_MBUB, 64'h0, "dual_mbub");

        step();
        chk(K_EICODE, 64'h1, "dual_icode"); chk(K_SCNT, 64'h2, "dual_scnt");
        chk(K_BCNT, 64'h3, "dual_bcnt");    chk(K_SCNT4, 64'h2, "dual_scnt4");

        for (int i = 0; i < 15; i++) begin
            step(); d_icode = 4'h5; d_dstm = 4'h4;
            step(); d_icode = 4'h6; d_srcb = 4'h4;
            chk(K_EBUB, 64'h1, "sat_ebub");
        end

        step();
        chk(K_SCNT, 64'd17, "sat_scnt32"); chk(K_BCNT, 64'd18, "sat_bcnt32");
        chk(K_SCNT4, 64'hF, "sat_scnt4");  chk(K_BCNT4, 64'hF, "sat_bcnt4");

        step(); d_icode = 4'h6; d_vala = 64'h77;
        step(); rst_n = 1'b0;
        chk(K_EICODE, 64'h1, "arst_icode"); chk(K_EDSTE, 64'hF, "arst_dstE");
        chk(K_EVALA, 64'h0, "arst_valA");   chk(K_SCNT, 64'h0, "arst_scnt");
        chk(K_BCNT, 64'h0, "arst_bcnt");    chk(K_SCNT4, 64'h0, "arst_scnt4");

        step(); rst_n = 1'b1; d_icode = 4'h6; d_vala = 64'h55;
        chk(K_EICODE, 64'h1, "arst_hold_icode");

        step();
        chk(K_EICODE, 64'h6, "post_rst_icode"); chk(K_EVALA, 64'h55, "post_rst_valA");
        chk(K_SCNT, 64'h0, "post_rst_scnt");

        step();
        step();
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
